dom_gf16_inverter_pipe: RTL and testbench
=========================================

Name: dom_gf16_inverter_pipe

Overview:
- Parametrised, stallable successor of the masked GF(2^4) inverter in the DOM AES S-box.
- Takes SHARES-share Boolean-masked GF(2^4) elements in the S-box normal-basis tower representation and returns a masked inverse, with 0 mapping to 0.
- Adds what the current inverter lacks: selectable 5-/8-stage-S-box timing, a valid pipeline, a global enable (stall), and per-stage randomness-request strobes.
- Sits between the GF(2^8)→GF(2^4) linear map/multiply stage and the output GF(2^4) multipliers.

Parameters:
- SHARES, 2, number of Boolean shares (2..4); d = SHARES-1 protection order.
- EIGHT_STAGED_SBOX, 0, 0: two-register latency (5-stage S-box); 1: E is registered before the second multiplier layer, giving three-register latency.
- FIRST_ORDER_OPTIMIZATION, 1, passed to all DOM multipliers. It is legal only when SHARES==2; otherwise it is forced to 0 internally.
- LATENCY, derived (2+EIGHT_STAGED_SBOX), not user-settable.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  asynchronous active-low reset.
- EnxSI  in  1  global enable. 0 freezes every register, including those inside the DOM multipliers.
- InValidxSI  in  1  _XxDI holds a valid element this cycle.
- _XxDI  in  4*SHARES  input shares; share i = bits [4i+3:4i]; A = bits 3:2, B = bits 1:0.
- _Zmul1xDI, _Zmul2xDI, _Zmul3xDI  in  SHARES*(SHARES-1) each  fresh DOM masks for A×B, A×E, B×E.
- _Bmul1xDI, _Bmul2xDI, _Bmul3xDI  in  2*SHARES each  blinding bits (first-order optimisation only; ignored otherwise).
- RandReq1xSO  out  1  Zmul1/Bmul1 are sampled at the next enabled edge.
- RandReq23xSO  out  1  Zmul2/3 and Bmul2/3 are sampled at the next enabled edge.
- OutValidxSO  out  1  _QxDO holds a valid result.
- _QxDO  out  4*SHARES  output shares; share i = {B×E, A×E}.

Behaviour:
- Reset (async, RstxBI=0):
  - All data registers (A, B, C, optional E, multiplier internals) and the valid shift register clear to 0 immediately.
  - OutValidxSO=0, RandReq*=0, _QxDO=0.
  - Release is synchronous to the next rising edge. Reset mid-operation discards all in-flight elements; no output valid is produced for them.
- Datapath per share i, stage 0 (combinational on input):
  - d = {A0^B0, A1^B1} (square of A+B).
  - C = {d0, d1^d0} (scale by N).
  - A, B, C are registered in stage 1.
  - Multiplier 1 computes A×B from the unregistered A and B, with its internal register aligned to stage 1.
- Stage 1→2:
  - E = {C0^P0, C1^P1}, where P = A×B output.
  - EIGHT_STAGED_SBOX=1: E, A and B are each registered once more, and multipliers 2 and 3 consume the registered copies.
  - Multipliers 2 and 3 take (A_reg, E) and (B_reg, E). Their outputs drive _QxDO directly after their internal register.
- Latency: an element accepted at enabled edge k appears at edge k+LATENCY. Count only edges with EnxSI=1; disabled edges are skipped. Throughput is 1 element per enabled cycle.
- Valid pipe: a LATENCY-deep shift register fed by InValidxSI, advancing only when EnxSI=1. OutValidxSO is its last bit.
- Data advances with EnxSI regardless of valid; bubbles carry whatever data is present, and _QxDO is don't-care when OutValidxSO=0.
- Randomness requests:
  - RandReq1xSO = InValidxSI & EnxSI.
  - RandReq23xSO = EnxSI & (valid bit at the stage feeding multipliers 2/3).
  - Randomness is sampled only on edges with EnxSI=1 and must be fresh per request. Masks presented while a request is low are unused.
- Stall: with EnxSI=0, all outputs hold their values and no mask input is sampled. Any stall length, including a stall on the same edge as a new InValidxSI, loses nothing.
- Correctness: XOR of the _QxDO shares equals inv(XOR of the _XxDI shares), bit-exact with the team's unmasked GF(2^4) normal-basis inverter model. inv(0)=0.
- Security: no share recombination before a DOM register. The unregistered E never feeds both a cross-domain term and a register output in the same domain.

Test Plan:
- SHARES=2, EIGHT_STAGED_SBOX=0, EnxSI=1; sweep all 16 unmasked x with random masks, one per cycle, InValidxSI=1 → unmasked outputs match the model 2 cycles later; x=0 gives 0; inv(inv(x))=x holds for all 16.
- Same sweep with EIGHT_STAGED_SBOX=1 and SHARES=3 → identical unmasked results at latency 3; OutValidxSO pattern equals the input valid pattern delayed 3.
- Input x=4'hB valid at cycle 0; hold EnxSI=0 during cycles 1–5, then 1 → OutValidxSO rises exactly 2 enabled edges after acceptance; output share vectors are unchanged throughout the stall.
- Alternate InValidxSI 1,0,1,0 with masks randomised every cycle → RandReq1xSO mirrors InValidxSI; RandReq23xSO follows it by 1 enabled cycle (2 when eight-staged); no valid output is corrupted.
- Assert RstxBI=0 asynchronously mid-cycle with 2 elements in flight → OutValidxSO and _QxDO go to 0 before the next edge; no stale valid appears after release.
- Fixed x, 1000 trials with random masks per trial → the unmasked result is constant while every individual output share toggles (statistical sanity check, not a leakage proof).

Source files
------------

// File: rtl/dom_gf16_inverter_pipe.sv
`default_nettype none
// ============================================================================
// Module  : dom_gf16_inverter_pipe
// Brief   : Stallable, valid-pipelined DOM-masked GF(2^4) normal-basis inverter.
// Revision: 1.0
// ============================================================================

// Masked GF(2^2) multiplier with one register stage. DEP=1 blinds Y with fresh
// shares of B so Y+B may be recombined after the register (two-share use only).
module dom_gf4_mul #(
    parameter int SHARES = 2,
    parameter int DEP    = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_en,
    input  logic [2*SHARES-1:0]           i_x,
    input  logic [2*SHARES-1:0]           i_y,
    input  logic [SHARES*(SHARES-1)-1:0]  i_z,
    input  logic [2*SHARES-1:0]           i_b,
    output logic [2*SHARES-1:0]           o_q
);
    function automatic logic [1:0] f_mul(input logic [1:0] a, input logic [1:0] b);
        logic m;
        m = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ m, (a[0] & b[0]) ^ m};
    endfunction

    logic [2*SHARES-1:0]        w_yi;
    logic [2*SHARES*SHARES-1:0] w_terms;
    logic [2*SHARES-1:0]        w_s;

    for (genvar i = 0; i < SHARES; i++) begin : g_row
        for (genvar j = 0; j < SHARES; j++) begin : g_col
            logic [1:0] w_t;
            logic [1:0] r_t;
            if (i == j) begin : g_inner
                assign w_t = f_mul(i_x[2*i+:2], w_yi[2*j+:2]);
            end else begin : g_cross
                localparam int LO = (i < j) ? i : j;
                localparam int HI = (i < j) ? j : i;
                localparam int K  = LO*SHARES - (LO*(LO+1))/2 + (HI-LO-1);
                assign w_t = f_mul(i_x[2*i+:2], w_yi[2*j+:2]) ^ i_z[2*K+:2];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    r_t <= '0;
                else if (i_en) r_t <= w_t;
            end
            assign w_terms[2*(i*SHARES+j)+:2] = r_t;
        end
    end

    // Shares only meet after the DOM register.
    always_comb begin
        w_s = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                w_s[2*i+:2] = w_s[2*i+:2] ^ w_terms[2*(i*SHARES+j)+:2];
            end
        end
    end

    if (DEP != 0) begin : g_dep
        logic [2*SHARES-1:0] r_x;
        logic [2*SHARES-1:0] r_yb;
        logic [1:0]          w_yb;
        assign w_yi = i_b;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_x  <= '0;
                r_yb <= '0;
            end else if (i_en) begin
                r_x  <= i_x;
                r_yb <= i_y ^ i_b;
            end
        end
        always_comb begin
            w_yb = '0;
            for (int i = 0; i < SHARES; i++) w_yb = w_yb ^ r_yb[2*i+:2];
        end
        // X*(Y+B) + X*B = X*Y
        for (genvar i = 0; i < SHARES; i++) begin : g_out
            assign o_q[2*i+:2] = f_mul(r_x[2*i+:2], w_yb) ^ w_s[2*i+:2];
        end
    end else begin : g_indep
        logic w_unused_b;
        assign w_unused_b = ^i_b;
        assign w_yi = i_y;
        assign o_q  = w_s;
    end
endmodule

module dom_gf16_inverter_pipe #(
    parameter int SHARES                   = 2,
    parameter int EIGHT_STAGED_SBOX        = 0,
    parameter int FIRST_ORDER_OPTIMIZATION = 1
) (
    input  logic                          ClkxCI,
    input  logic                          RstxBI,
    input  logic                          EnxSI,
    input  logic                          InValidxSI,
    input  logic [4*SHARES-1:0]           _XxDI,
    input  logic [SHARES*(SHARES-1)-1:0]  _Zmul1xDI,
    input  logic [SHARES*(SHARES-1)-1:0]  _Zmul2xDI,
    input  logic [SHARES*(SHARES-1)-1:0]  _Zmul3xDI,
    input  logic [2*SHARES-1:0]           _Bmul1xDI,
    input  logic [2*SHARES-1:0]           _Bmul2xDI,
    input  logic [2*SHARES-1:0]           _Bmul3xDI,
    output logic                          RandReq1xSO,
    output logic                          RandReq23xSO,
    output logic                          OutValidxSO,
    output logic [4*SHARES-1:0]           _QxDO
);
    localparam int LATENCY = 2 + EIGHT_STAGED_SBOX;
    localparam int DEP     = (SHARES == 2 && FIRST_ORDER_OPTIMIZATION != 0) ? 1 : 0;

    logic [2*SHARES-1:0] w_a, w_b, w_c, w_p, w_e;
    logic [2*SHARES-1:0] w_am, w_bm, w_em, w_q2, w_q3;
    logic [2*SHARES-1:0] r_a, r_b, r_c;
    logic [LATENCY-1:0]  r_valid;

    // Per share: C = N * (A+B)^2, all linear so no cross-share mixing.
    for (genvar i = 0; i < SHARES; i++) begin : g_s0
        logic [1:0] w_d;
        assign w_a[2*i+:2] = _XxDI[4*i+2+:2];
        assign w_b[2*i+:2] = _XxDI[4*i+:2];
        assign w_d         = {w_a[2*i] ^ w_b[2*i], w_a[2*i+1] ^ w_b[2*i+1]};
        assign w_c[2*i+:2] = {w_d[0], w_d[1] ^ w_d[0]};
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_valid <= '0;
        end else if (EnxSI) begin
            r_a     <= w_a;
            r_b     <= w_b;
            r_c     <= w_c;
            r_valid <= {r_valid[LATENCY-2:0], InValidxSI};
        end
    end

    dom_gf4_mul #(.SHARES(SHARES), .DEP(DEP)) u_mul1 (
        .clk(ClkxCI), .rst_n(RstxBI), .i_en(EnxSI),
        .i_x(w_a), .i_y(w_b), .i_z(_Zmul1xDI), .i_b(_Bmul1xDI), .o_q(w_p)
    );

    // E = (C + A*B)^-1, the GF(2^2) inverse being a bit swap.
    for (genvar i = 0; i < SHARES; i++) begin : g_s1
        assign w_e[2*i+:2] = {r_c[2*i] ^ w_p[2*i], r_c[2*i+1] ^ w_p[2*i+1]};
    end

    if (EIGHT_STAGED_SBOX != 0) begin : g_eight
        logic [2*SHARES-1:0] r_e, r_a2, r_b2;
        always_ff @(posedge ClkxCI or negedge RstxBI) begin
            if (!RstxBI) begin
                r_e  <= '0;
                r_a2 <= '0;
                r_b2 <= '0;
            end else if (EnxSI) begin
                r_e  <= w_e;
                r_a2 <= r_a;
                r_b2 <= r_b;
            end
        end
        assign w_am = r_a2;
        assign w_bm = r_b2;
        assign w_em = r_e;
    end else begin : g_five
        assign w_am = r_a;
        assign w_bm = r_b;
        assign w_em = w_e;
    end

    dom_gf4_mul #(.SHARES(SHARES), .DEP(DEP)) u_mul2 (
        .clk(ClkxCI), .rst_n(RstxBI), .i_en(EnxSI),
        .i_x(w_am), .i_y(w_em), .i_z(_Zmul2xDI), .i_b(_Bmul2xDI), .o_q(w_q2)
    );

    dom_gf4_mul #(.SHARES(SHARES), .DEP(DEP)) u_mul3 (
        .clk(ClkxCI), .rst_n(RstxBI), .i_en(EnxSI),
        .i_x(w_bm), .i_y(w_em), .i_z(_Zmul3xDI), .i_b(_Bmul3xDI), .o_q(w_q3)
    );

    for (genvar i = 0; i < SHARES; i++) begin : g_q
        assign _QxDO[4*i+:4] = {w_q3[2*i+:2], w_q2[2*i+:2]};
    end

    assign RandReq1xSO  = InValidxSI & EnxSI & RstxBI;
    assign RandReq23xSO = EnxSI & r_valid[LATENCY-2];
    assign OutValidxSO  = r_valid[LATENCY-1];
endmodule
`default_nettype wire

// File: tb/tb_dom_gf16_inverter_pipe.sv
`default_nettype none
// Bench: two instances (2 shares/5-stage, 3 shares/8-stage) driven in lockstep,
// checked against a brute-force GF(2^4) inverse through a scoreboard.
module tb_dom_gf16_inverter_pipe;
    localparam int S0  = 2;
    localparam int S1  = 3;
    localparam int Z0W = S0*(S0-1);
    localparam int Z1W = S1*(S1-1);

    logic ClkxCI = 1'b0;
    logic RstxBI, EnxSI, InValidxSI;

    logic [4*S0-1:0] x0, q0;
    logic [Z0W-1:0]  z01, z02, z03;
    logic [2*S0-1:0] b01, b02, b03;
    logic            rq1_0, rq23_0, ov0;

    logic [4*S1-1:0] x1, q1;
    logic [Z1W-1:0]  z11, z12, z13;
    logic [2*S1-1:0] b11, b12, b13;
    logic            rq1_1, rq23_1, ov1;

    always #5 ClkxCI = ~ClkxCI;

    dom_gf16_inverter_pipe #(.SHARES(S0), .EIGHT_STAGED_SBOX(0), .FIRST_ORDER_OPTIMIZATION(1)) u_dut0 (
        .ClkxCI(ClkxCI), .RstxBI(RstxBI), .EnxSI(EnxSI), .InValidxSI(InValidxSI),
        ._XxDI(x0), ._Zmul1xDI(z01), ._Zmul2xDI(z02), ._Zmul3xDI(z03),
        ._Bmul1xDI(b01), ._Bmul2xDI(b02), ._Bmul3xDI(b03),
        .RandReq1xSO(rq1_0), .RandReq23xSO(rq23_0), .OutValidxSO(ov0), ._QxDO(q0)
    );

    dom_gf16_inverter_pipe #(.SHARES(S1), .EIGHT_STAGED_SBOX(1), .FIRST_ORDER_OPTIMIZATION(1)) u_dut1 (
        .ClkxCI(ClkxCI), .RstxBI(RstxBI), .EnxSI(EnxSI), .InValidxSI(InValidxSI),
        ._XxDI(x1), ._Zmul1xDI(z11), ._Zmul2xDI(z12), ._Zmul3xDI(z13),
        ._Bmul1xDI(b11), ._Bmul2xDI(b12), ._Bmul3xDI(b13),
        .RandReq1xSO(rq1_1), .RandReq23xSO(rq23_1), .OutValidxSO(ov1), ._QxDO(q1)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] sb0[$];
    logic [3:0] sb1[$];
    logic [1:0] vp0;
    logic [2:0] vp1;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
    } vec_t;
    vec_t tab[16];

    // GF(2^2), normal basis {W^2, W}: bit1 = W^2 coefficient.
    function automatic logic [1:0] m_mul4(input logic [1:0] a, input logic [1:0] b);
        logic m;
        m = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ m, (a[0] & b[0]) ^ m};
    endfunction

    // GF(2^4) over GF(2^2) with Y^2+Y+N, N=W^2; element {g1,g0} = g1*Y^4 + g0*Y.
    // Converted to polynomial form u*Y+v using Y^4 = Y+1.
    function automatic logic [3:0] m_mul16(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] ua, va, ub, vb, u, v;
        ua = a[3:2] ^ a[1:0]; va = a[3:2];
        ub = b[3:2] ^ b[1:0]; vb = b[3:2];
        u  = m_mul4(ua, ub) ^ m_mul4(ua, vb) ^ m_mul4(va, ub);
        v  = m_mul4(m_mul4(ua, ub), 2'b10) ^ m_mul4(va, vb);
        return {v, u ^ v};
    endfunction

    function automatic logic [3:0] m_inv(input logic [3:0] x);
        for (int y = 1; y < 16; y++) begin
            if (m_mul16(x, 4'(y)) == 4'hF) return 4'(y);
        end
        return 4'h0;
    endfunction

    function automatic logic [3:0] um0(input logic [4*S0-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < S0; i++) r = r ^ v[4*i+:4];
        return r;
    endfunction

    function automatic logic [3:0] um1(input logic [4*S1-1:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < S1; i++) r = r ^ v[4*i+:4];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] x);
        logic [31:0] r;
        logic [3:0]  acc0, acc1;
        acc0 = x;
        acc1 = x;
        for (int i = 0; i < S0-1; i++) begin
            r = $urandom; x0[4*i+:4] = r[3:0]; acc0 = acc0 ^ r[3:0];
        end
        x0[4*(S0-1)+:4] = acc0;
        for (int i = 0; i < S1-1; i++) begin
            r = $urandom; x1[4*i+:4] = r[3:0]; acc1 = acc1 ^ r[3:0];
        end
        x1[4*(S1-1)+:4] = acc1;
        r = $urandom; z01 = r[Z0W-1:0]; r = $urandom; z02 = r[Z0W-1:0];
        r = $urandom; z03 = r[Z0W-1:0];
        r = $urandom; z11 = r[Z1W-1:0]; r = $urandom; z12 = r[Z1W-1:0];
        r = $urandom; z13 = r[Z1W-1:0];
        r = $urandom; b01 = r[2*S0-1:0]; r = $urandom; b02 = r[2*S0-1:0];
        r = $urandom; b03 = r[2*S0-1:0];
        r = $urandom; b11 = r[2*S1-1:0]; r = $urandom; b12 = r[2*S1-1:0];
        r = $urandom; b13 = r[2*S1-1:0];
    endtask

    // One clock: drive, check request strobes, advance, check valids and data.
    task automatic step(input logic en, input logic vld, input logic [3:0] x, input logic [3:0] exp);
        EnxSI = en;
        InValidxSI = vld;
        drive(x);
        #1;
        chk("req1_0", 32'(rq1_0), 32'(en & vld));
        chk("req1_1", 32'(rq1_1), 32'(en & vld));
        chk("req23_0", 32'(rq23_0), 32'(en & vp0[0]));
        chk("req23_1", 32'(rq23_1), 32'(en & vp1[1]));
        @(posedge ClkxCI);
        #1;
        if (en) begin
            vp0 = {vp0[0], vld};
            vp1 = {vp1[1:0], vld};
            if (vld) begin
                sb0.push_back(exp);
                sb1.push_back(exp);
            end
            chk("ovalid0", 32'(ov0), 32'(vp0[1]));
            chk("ovalid1", 32'(ov1), 32'(vp1[2]));
            if (vp0[1]) begin
                if (sb0.size() == 0) chk("sb0_underflow", 32'(1), 32'(0));
                else chk("q0", 32'(um0(q0)), 32'(sb0.pop_front()));
            end
            if (vp1[2]) begin
                if (sb1.size() == 0) chk("sb1_underflow", 32'(1), 32'(0));
                else chk("q1", 32'(um1(q1)), 32'(sb1.pop_front()));
            end
        end
    endtask

    task automatic flush();
        repeat (4) step(1'b1, 1'b0, 4'h0, 4'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [4*S0-1:0] s0, p0;
        logic [4*S1-1:0] s1, p1;
        logic            sv0, sv1;
        logic [S0-1:0]   tg0;
        logic [S1-1:0]   tg1;

        for (int i = 0; i < 16; i++) begin
            tab[i].x = 4'(i);
            tab[i].y = m_inv(4'(i));
        end

        RstxBI = 1'b0; EnxSI = 1'b1; InValidxSI = 1'b1;
        vp0 = '0; vp1 = '0;
        drive(4'h5);
        repeat (2) @(posedge ClkxCI);
        #1;
        chk("rst_ov0", 32'(ov0), 32'(0));
        chk("rst_ov1", 32'(ov1), 32'(0));
        chk("rst_q0", 32'(q0), 32'(0));
        chk("rst_q1", 32'(q1), 32'(0));
        chk("rst_req1", 32'({rq1_0, rq1_1}), 32'(0));
        chk("rst_req23", 32'({rq23_0, rq23_1}), 32'(0));
        InValidxSI = 1'b0;
        @(negedge ClkxCI);
        RstxBI = 1'b1;

        // Full sweep, then the inverse sweep expecting the original operand back.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, tab[i].x, tab[i].y);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, tab[i].y, tab[i].x);
        flush();

        // Alternating valid: request strobes track the valid pipe.
        for (int i = 0; i < 8; i++) step(1'b1, 1'(i % 2 == 0), 4'(3*i+1), m_inv(4'(3*i+1)));
        flush();

        // Stall right after acceptance, with a new element waiting at the input.
        step(1'b1, 1'b1, 4'hB, m_inv(4'hB));
        s0 = q0; s1 = q1; sv0 = ov0; sv1 = ov1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 4'h7, m_inv(4'h7));
            chk("stall_q0", 32'(q0), 32'(s0));
            chk("stall_q1", 32'(q1), 32'(s1));
            chk("stall_ov", 32'({ov0, ov1}), 32'({sv0, sv1}));
        end
        step(1'b1, 1'b1, 4'h7, m_inv(4'h7));
        step(1'b1, 1'b0, 4'h0, 4'h0);
        chk("stall_rise0", 32'(ov0), 32'(1));
        flush();

        // Asynchronous reset with elements in flight.
        step(1'b1, 1'b1, 4'h3, m_inv(4'h3));
        step(1'b1, 1'b1, 4'hA, m_inv(4'hA));
        step(1'b1, 1'b1, 4'hD, m_inv(4'hD));
        #2;
        RstxBI = 1'b0;
        #1;
        chk("arst_ov0", 32'(ov0), 32'(0));
        chk("arst_ov1", 32'(ov1), 32'(0));
        chk("arst_q0", 32'(q0), 32'(0));
        chk("arst_q1", 32'(q1), 32'(0));
        chk("arst_req", 32'({rq1_0, rq1_1, rq23_0, rq23_1}), 32'(0));
        sb0.delete(); sb1.delete();
        vp0 = '0; vp1 = '0;
        InValidxSI = 1'b0;
        @(negedge ClkxCI);
        RstxBI = 1'b1;
        repeat (5) step(1'b1, 1'b0, 4'h0, 4'h0);

        // Fixed operand, fresh masks each trial: every output share must move.
        tg0 = '0; tg1 = '0;
        p0 = q0; p1 = q1;
        for (int t = 0; t < 1000; t++) begin
            step(1'b1, 1'b1, 4'h9, m_inv(4'h9));
            if (t >= 4) begin
                for (int i = 0; i < S0; i++) if (q0[4*i+:4] != p0[4*i+:4]) tg0[i] = 1'b1;
                for (int i = 0; i < S1; i++) if (q1[4*i+:4] != p1[4*i+:4]) tg1[i] = 1'b1;
            end
            p0 = q0; p1 = q1;
        end
        chk("toggle0", 32'(tg0), 32'({S0{1'b1}}));
        chk("toggle1", 32'(tg1), 32'({S1{1'b1}}));
        flush();
        chk("sb0_empty", 32'(sb0.size()), 32'(0));
        chk("sb1_empty", 32'(sb1.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
